flit_fifo: RTL
==============

FLIT_FIFO -- requirements
Module: flit_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of flit slots; power of two, 2..16.
REQ-002 SHALL have parameter FLIT_W, default 32, flit width in bits.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port flit_in  input  FLIT_W  flit from the upstream link.
REQ-006 SHALL have port valid_in  input  1  flit_in carries a flit this cycle.
REQ-007 SHALL have port ready_out  output  1  FIFO can accept a flit; equals ~full.
REQ-008 SHALL have port read_en  input  1  downstream consumes the head flit this cycle.
REQ-009 SHALL have port flit_out  output  FLIT_W  head flit, first-word fall-through; all zeros when empty.
REQ-010 SHALL have port flit_id  output  3  flit_out[31:29], head flit type, feeds the routing stage.
REQ-011 SHALL have port dst_addr  output  4  flit_out[28:25], head flit destination {y[1:0],x[1:0]}.
REQ-012 SHALL have port empty  output  1  no flit stored.
REQ-013 SHALL have port full  output  1  DEPTH flits stored.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  number of stored flits.
REQ-015 SHALL have port frame_err  output  1  sticky packet-framing violation flag.

Function
REQ-016 SHALL accept a write when valid_in=1 and full=0; the flit is stored at wr_ptr, and wr_ptr increments modulo DEPTH.
REQ-017 SHALL drop a write attempted while full=1, including when read_en=1 in the same cycle, with no state change from the write.
REQ-018 SHALL perform a read when read_en=1 and empty=0; rd_ptr increments modulo DEPTH.
REQ-019 SHALL ignore read_en while empty=1, including when a write occurs in the same cycle.
REQ-020 SHALL update count as +1 on write only, -1 on read only, and unchanged on simultaneous write and read.
REQ-021 SHALL derive empty as (count==0) and full as (count==DEPTH); both are valid in the cycle after the updating edge.
REQ-022 SHALL present a flit on flit_out, flit_id and dst_addr one cycle after its write edge when the FIFO was empty, with no extra read latency.
REQ-023 SHALL use the flit_id encodings HEADER=3'b001, PAYLOAD=3'b010 and TAIL=3'b100.
REQ-024 SHALL implement the framing checker as an FSM with states IDLE and IN_PKT, advanced only on accepted writes.
REQ-025 SHALL make these framing-checker transitions:
- IDLE + HEADER -> IN_PKT.
- IN_PKT + TAIL -> IDLE.
- IN_PKT + PAYLOAD -> IN_PKT.
REQ-026 SHALL set frame_err on any other accepted flit: PAYLOAD or TAIL in IDLE, HEADER in IN_PKT, or an unknown code; the flit is still stored and the FSM state is unchanged.
REQ-027 SHALL hold frame_err at 1 until reset.

Reset
REQ-028 SHALL, while rst=1, clear wr_ptr, rd_ptr and count to 0, set the FSM to IDLE and clear frame_err to 0.
REQ-029 SHALL drive empty=1, full=0, ready_out=0, flit_out=0, flit_id=0 and dst_addr=0 while rst=1.
REQ-030 SHALL discard all stored flits when rst is asserted mid-operation; storage contents need not be cleared.
REQ-031 SHALL ignore valid_in and read_en while rst=1.

Structure
REQ-032 SHALL take FLIT_W, the flit_id encodings (HEADER, PAYLOAD, TAIL) and the flit field bit positions from shared package noc_pkg; the routing stage uses the same package.
REQ-033 SHALL be a single module with no sub-modules; storage is a register array indexed by the pointers.

Verification
REQ-034 SHALL verify: after reset, write HEADER 0x2A000000 -> next cycle empty=0, flit_id=3'b001, dst_addr=4'h5, count=1.
REQ-035 SHALL verify: write 4 flits with DEPTH=4 -> full=1 and ready_out=0; a 5th write with read_en=1 is dropped -> count=3 and the 5th flit is never read.
REQ-036 SHALL verify: with count=2, simultaneous write and read -> count stays 2 and the head advances in order.
REQ-037 SHALL verify: 10 writes and reads crossing pointer wrap -> output order equals input order.
REQ-038 SHALL verify: write PAYLOAD while IDLE -> frame_err=1 next cycle and it stays 1 through a following valid HEADER/TAIL packet.
REQ-039 SHALL verify: with count=3, assert rst for one cycle -> empty=1, count=0, frame_err=0, and a read_en pulse afterwards has no effect.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC flit definitions: width, flit_id encodings, field positions.
package noc_pkg;
  localparam int FLIT_W = 32;

  localparam int ID_MSB  = 31;
  localparam int ID_LSB  = 29;
  localparam int DST_MSB = 28;
  localparam int DST_LSB = 25;

  localparam logic [2:0] HEADER  = 3'b001;
  localparam logic [2:0] PAYLOAD = 3'b010;
  localparam logic [2:0] TAIL    = 3'b100;

  typedef enum logic {
    ST_IDLE,
    ST_IN_PKT
  } frame_state_t;
endpackage

// File: rtl/flit_fifo.sv
// First-word fall-through flit FIFO with a sticky packet-framing checker.
// Head flit visible the cycle after its write; writes while full are dropped.
module flit_fifo #(
  parameter int DEPTH  = 4,
  parameter int FLIT_W = noc_pkg::FLIT_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [FLIT_W-1:0]          flit_in,
  input  logic                       valid_in,
  output logic                       ready_out,
  input  logic                       read_en,
  output logic [FLIT_W-1:0]          flit_out,
  output logic [2:0]                 flit_id,
  output logic [3:0]                 dst_addr,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       frame_err
);
  import noc_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count_q;
  logic              frame_err_q;
  frame_state_t      state;

  logic              empty_i;
  logic              full_i;
  logic              wr;
  logic              rd;
  logic [2:0]        id_in;

  assign empty_i = (count_q == '0);
  assign full_i  = (count_q == CW'(DEPTH));
  assign wr      = valid_in & ~full_i & ~rst;
  assign rd      = read_en & ~empty_i & ~rst;
  assign id_in   = flit_in[ID_MSB:ID_LSB];

  // Storage is not reset; pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wr_ptr] <= flit_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      state       <= ST_IDLE;
      frame_err_q <= 1'b0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (rd) rd_ptr <= rd_ptr + AW'(1);

      case ({wr, rd})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase

      // Illegal flits are still stored; they only raise the sticky flag.
      if (wr) begin
        case (state)
          ST_IDLE: begin
            if (id_in == HEADER) state <= ST_IN_PKT;
            else                 frame_err_q <= 1'b1;
          end
          ST_IN_PKT: begin
            if (id_in == TAIL)         state <= ST_IDLE;
            else if (id_in != PAYLOAD) frame_err_q <= 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign empty     = rst | empty_i;
  assign full      = ~rst & full_i;
  assign ready_out = ~rst & ~full_i;
  assign count     = rst ? '0 : count_q;
  assign frame_err = ~rst & frame_err_q;
  assign flit_out  = (rst | empty_i) ? '0 : mem[rd_ptr];
  assign flit_id   = flit_out[ID_MSB:ID_LSB];
  assign dst_addr  = flit_out[DST_MSB:DST_LSB];
endmodule
